// File: rtl/uart_host_tx.sv
// uart_host_tx: host-side 8N1 UART transmitter with a small byte FIFO.
// Bytes pushed over a valid/ready handshake are queued and serialised
// LSB first at a fixed bit period. Frames go out back to back while the
// FIFO holds data.
//
// Ports:
//   clk_48mhz   system clock, all logic on the rising edge
//   manualReset synchronous active-high reset (aborts frame, flushes FIFO)
//   tx_data     byte to transmit
//   tx_valid    tx_data valid this cycle
//   tx_ready    FIFO can accept a byte this cycle
//   tx_out      serial line, idle high
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes queued, excluding the frame in flight
module uart_host_tx #(
  parameter int CLOCKS_PER_BIT = 417,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk_48mhz,
  input  logic                        manualReset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLOCKS_PER_BIT);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLOCKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic push;
  logic pop;
  logic baud_done;
  logic fifo_nonempty;

  // Ready comes from the registered count only, so a full FIFO stays
  // not-ready even in the cycle it is popped.
  assign tx_ready      = (fifo_count != FULL_COUNT);
  assign fifo_nonempty = (fifo_count != '0);
  assign baud_done     = (baud == BAUD_LAST);
  assign push          = tx_valid && tx_ready && !manualReset;
  assign busy          = (state != IDLE) || fifo_nonempty;

  // The head is taken either from IDLE or at the end of a stop cell.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = fifo_nonempty;
      STOP:    pop = baud_done && fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (manualReset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (manualReset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_out  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (pop) begin
            shift  <= mem[rd_ptr];
            baud   <= '0;
            tx_out <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            tx_out  <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift  <= mem[rd_ptr];
              tx_out <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
